// File: rtl/dccm_arb_pkg.sv
// Shared types and byte-merge helper for the DCCM port arbiter.
package dccm_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRmwMerge
  } state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnC,
    OwnD,
    OwnRmw
  } owner_e;

  function automatic logic [7:0] merge_byte(input logic [7:0] new_byte,
                                            input logic [7:0] old_byte,
                                            input logic       sel_new);
    return sel_new ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dccm_arb_pick.sv
// Two-way fixed-priority picker (core over DMA) with an optional DMA anti-starvation counter.
// Optional feature: DCCM_ARB_STARVE_EN enables the starve counter.
module dccm_arb_pick
`ifdef DCCM_ARB_STARVE_EN
#(
  parameter int unsigned STARVE_MAX = 8
)
`endif
(
`ifdef DCCM_ARB_STARVE_EN
  input  logic clk,
  input  logic rstn,
`endif
  input  logic en,
  input  logic c_req,
  input  logic d_req,
  output logic c_win,
  output logic d_win
);

`ifdef DCCM_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            force_dma;

  assign force_dma = (starve_q == CntW'(STARVE_MAX));
  assign d_win     = en & d_req & (~c_req | force_dma);

  // Count only arbitrations the DMA actually lost; saturate at the threshold.
  always_comb begin
    starve_d = starve_q;
    if (d_win) begin
      starve_d = '0;
    end else if (en && d_req && !force_dma) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign d_win = en & d_req & ~c_req;
`endif

  assign c_win = en & c_req & ~d_win;

endmodule

// File: rtl/dccm_arbiter.sv
// Shares the DCCM port pair between core LSU and DMA; sub-word stores become read-modify-write.
// Optional feature: DCCM_ARB_STARVE_EN (DMA anti-starvation, threshold STARVE_MAX).
module dccm_arbiter
  import dccm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
`ifdef DCCM_ARB_STARVE_EN
  parameter int unsigned STARVE_MAX = 8,
`endif
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rstn,

  input  logic             c_req,
  input  logic             c_we,
  input  logic [AW-1:0]    c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  input  logic [NB-1:0]    c_wstrb,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [WIDTH-1:0] c_rdata,

  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [NB-1:0]    d_wstrb,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,

  output logic [AW-1:0]    m_raddr,
  output logic             m_rvalid_in,
  input  logic             m_rvalid,
  input  logic [WIDTH-1:0] m_rdata,
  output logic [AW-1:0]    m_waddr,
  output logic             m_wen,
  output logic [WIDTH-1:0] m_wdata
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]    wstrb_q, wstrb_d;

  logic             arb_en, win_c, win_d;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [NB-1:0]    sel_wstrb;
  logic [WIDTH-1:0] merged;

  // Gating with rstn keeps the combinational outputs at zero while reset is held.
  assign arb_en = rstn & (state_q == StIdle);

  dccm_arb_pick
`ifdef DCCM_ARB_STARVE_EN
  #(
    .STARVE_MAX (STARVE_MAX)
  )
`endif
  u_pick (
`ifdef DCCM_ARB_STARVE_EN
    .clk   (clk),
    .rstn  (rstn),
`endif
    .en    (arb_en),
    .c_req (c_req),
    .d_req (d_req),
    .c_win (win_c),
    .d_win (win_d)
  );

  assign c_gnt = win_c;
  assign d_gnt = win_d;

  assign sel_we    = win_c ? c_we    : d_we;
  assign sel_addr  = win_c ? c_addr  : d_addr;
  assign sel_wdata = win_c ? c_wdata : d_wdata;
  assign sel_wstrb = win_c ? c_wstrb : d_wstrb;

  always_comb begin
    merged = '0;
    for (int i = 0; i < int'(NB); i++) begin
      merged[i*8 +: 8] = merge_byte(wdata_q[i*8 +: 8], m_rdata[i*8 +: 8], wstrb_q[i]);
    end
  end

  always_comb begin
    state_d     = StIdle;
    owner_d     = OwnNone;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    m_raddr     = '0;
    m_rvalid_in = 1'b0;
    m_waddr     = '0;
    m_wen       = 1'b0;
    m_wdata     = '0;

    if (win_c || win_d) begin
      if (!sel_we) begin
        m_raddr     = sel_addr;
        m_rvalid_in = 1'b1;
        owner_d     = win_c ? OwnC : OwnD;
      end else if (&sel_wstrb) begin
        m_waddr = sel_addr;
        m_wen   = 1'b1;
        m_wdata = sel_wdata;
      end else if (|sel_wstrb) begin
        // Fetch the old word; the merge and write happen next cycle.
        m_raddr     = sel_addr;
        m_rvalid_in = 1'b1;
        owner_d     = OwnRmw;
        state_d     = StRmwMerge;
        addr_d      = sel_addr;
        wdata_d     = sel_wdata;
        wstrb_d     = sel_wstrb;
      end
    end

    if (rstn && state_q == StRmwMerge) begin
      m_waddr = addr_q;
      m_wen   = 1'b1;
      m_wdata = merged;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign c_rvalid = rstn & m_rvalid & (owner_q == OwnC);
  assign d_rvalid = rstn & m_rvalid & (owner_q == OwnD);
  assign c_rdata  = rstn ? m_rdata : '0;
  assign d_rdata  = rstn ? m_rdata : '0;

endmodule

// File: tb/tb_dccm_arbiter.sv
// Self-checking bench for dccm_arbiter: directed scenarios, then random traffic against a memory model.
module tb_dccm_arbiter;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned NB    = 4;
`ifdef DCCM_ARB_STARVE_EN
  localparam int StarveMax = 4;
`else
  localparam int StarveMax = 1 << 30;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             c_req, c_we, d_req, d_we;
  logic [AW-1:0]    c_addr, d_addr;
  logic [WIDTH-1:0] c_wdata, d_wdata;
  logic [NB-1:0]    c_wstrb, d_wstrb;
  logic             c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [WIDTH-1:0] c_rdata, d_rdata;
  logic [AW-1:0]    m_raddr, m_waddr;
  logic             m_rvalid_in, m_wen;
  logic             m_rvalid = 1'b0;
  logic [WIDTH-1:0] m_rdata = '0;
  logic [WIDTH-1:0] m_wdata;

  logic [WIDTH-1:0] dmem    [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             pl_en = 1'b0;
  logic [AW-1:0]    pl_addr = '0;
  logic [WIDTH-1:0] pl_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int               first_d, win, cnt;
  logic             rmw_busy, busy_next;
  logic             exp_c_rv, exp_d_rv;
  logic [WIDTH-1:0] exp_c_data, exp_d_data, exp_old;
  logic             t_we;
  logic [AW-1:0]    t_addr;
  logic [WIDTH-1:0] t_data;
  logic [NB-1:0]    t_strb;

`ifdef DCCM_ARB_STARVE_EN
  dccm_arbiter #(
    .STARVE_MAX (4)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .c_req       (c_req),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_wstrb     (c_wstrb),
    .c_gnt       (c_gnt),
    .c_rvalid    (c_rvalid),
    .c_rdata     (c_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_wstrb     (d_wstrb),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .m_raddr     (m_raddr),
    .m_rvalid_in (m_rvalid_in),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .m_waddr     (m_waddr),
    .m_wen       (m_wen),
    .m_wdata     (m_wdata)
  );
`else
  dccm_arbiter u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .c_req       (c_req),
    .c_we        (c_we),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_wstrb     (c_wstrb),
    .c_gnt       (c_gnt),
    .c_rvalid    (c_rvalid),
    .c_rdata     (c_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_wstrb     (d_wstrb),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .m_raddr     (m_raddr),
    .m_rvalid_in (m_rvalid_in),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .m_waddr     (m_waddr),
    .m_wen       (m_wen),
    .m_wdata     (m_wdata)
  );
`endif

  always #5 clk = ~clk;

  // DCCM stand-in: one-cycle read latency, synchronous write.
  always @(posedge clk) begin
    m_rvalid <= m_rvalid_in;
    if (m_rvalid_in) m_rdata <= dmem[m_raddr];
    if (m_wen) dmem[m_waddr] <= m_wdata;
    if (pl_en) dmem[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ref_merge(input logic [WIDTH-1:0] old_w,
                                                 input logic [WIDTH-1:0] new_w,
                                                 input logic [NB-1:0] strb);
    logic [WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(NB); i++) if (strb[i]) mask[i*8 +: 8] = 8'hFF;
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic ref_store(input logic [AW-1:0] a, input logic [WIDTH-1:0] dat,
                           input logic [NB-1:0] s);
    ref_mem[a] = ref_merge(ref_mem[a], dat, s);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] dat);
    pl_en = 1'b1; pl_addr = a; pl_data = dat;
    next_cycle();
    pl_en = 1'b0;
    ref_mem[a] = dat;
  endtask

  function automatic logic [NB-1:0] rand_strb();
    logic [NB-1:0] one;
    one = 4'b0001;
    case ($urandom_range(2, 0))
      0:       return 4'hF;
      1:       return 4'($urandom_range(15, 0));
      default: return one << $urandom_range(3, 0);
    endcase
  endfunction

  task automatic drive_c(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] dat,
                         input logic [NB-1:0] s);
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = dat; c_wstrb = s;
  endtask

  task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] dat,
                         input logic [NB-1:0] s);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = dat; d_wstrb = s;
  endtask

  initial begin
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    next_cycle();
    for (int i = 0; i < 32; i++) preload(AW'(i), $urandom);
    preload(10'd5, 32'hDEADBEEF);
    preload(10'd3, 32'h11223344);
    preload(10'd7, 32'hCAFEF00D);

    // Reset state, with a request already present.
    drive_c(1'b0, 10'd5, '0, '0);
    #4;
    check("reset_outputs", {c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, m_raddr,
                            m_rvalid_in, m_waddr, m_wen, m_wdata}, '0);
    next_cycle();
    c_req = 0;
    rstn = 1'b1;

    // 1: core load
    next_cycle();
    drive_c(1'b0, 10'd5, '0, '0);
    #4;
    check("t1_c_gnt", c_gnt, 1);
    check("t1_m_raddr", m_raddr, 5);
    check("t1_m_rvalid_in", m_rvalid_in, 1);
    exp_old = ref_mem[5];
    next_cycle();
    c_req = 0;
    #4;
    check("t1_c_rvalid", c_rvalid, 1);
    check("t1_c_rdata", c_rdata, exp_old);
    check("t1_d_rvalid", d_rvalid, 0);

    // 2: simultaneous full stores
    next_cycle();
    drive_c(1'b1, 10'd10, 32'hA5A50001, 4'hF);
    drive_d(1'b1, 10'd11, 32'h5A5A0002, 4'hF);
    #4;
    check("t2_c_gnt", {c_gnt, d_gnt}, 2'b10);
    check("t2_c_write", {m_wen, m_waddr, m_wdata}, {1'b1, 10'd10, 32'hA5A50001});
    ref_store(10'd10, 32'hA5A50001, 4'hF);
    next_cycle();
    c_req = 0;
    #4;
    check("t2_d_gnt", {c_gnt, d_gnt}, 2'b01);
    check("t2_d_write", {m_wen, m_waddr, m_wdata}, {1'b1, 10'd11, 32'h5A5A0002});
    ref_store(10'd11, 32'h5A5A0002, 4'hF);

    // 3: DMA partial store, core load waiting behind it
    next_cycle();
    d_req = 0;
    drive_d(1'b1, 10'd3, 32'h0000AB00, 4'b0010);
    #4;
    check("t3_d_gnt", d_gnt, 1);
    check("t3_rmw_read", {m_wen, m_rvalid_in, m_raddr}, {1'b0, 1'b1, 10'd3});
    ref_store(10'd3, 32'h0000AB00, 4'b0010);
    next_cycle();
    d_req = 0;
    drive_c(1'b0, 10'd3, '0, '0);
    #4;
    check("t3_no_gnt", {c_gnt, d_gnt}, 2'b00);
    check("t3_merge_write", {m_wen, m_waddr, m_wdata}, {1'b1, 10'd3, ref_mem[3]});
    check("t3_no_rvalid", {c_rvalid, d_rvalid}, 2'b00);
    next_cycle();
    #4;
    check("t3_c_gnt_after", c_gnt, 1);
    next_cycle();
    c_req = 0;
    #4;
    check("t3_readback", {c_rvalid, c_rdata}, {1'b1, ref_mem[3]});

    // 6: load then store to the same address on the next cycle
    next_cycle();
    drive_c(1'b0, 10'd7, '0, '0);
    #4;
    check("t6_c_gnt", c_gnt, 1);
    exp_old = ref_mem[7];
    next_cycle();
    c_req = 0;
    drive_d(1'b1, 10'd7, 32'h77777777, 4'hF);
    #4;
    check("t6_d_gnt", d_gnt, 1);
    check("t6_old_data", {c_rvalid, c_rdata}, {1'b1, exp_old});
    ref_store(10'd7, 32'h77777777, 4'hF);
    next_cycle();
    d_req = 0;
    drive_c(1'b0, 10'd7, '0, '0);
    #4;
    check("t6_c_gnt2", c_gnt, 1);
    next_cycle();
    c_req = 0;
    #4;
    check("t6_new_data", {c_rvalid, c_rdata}, {1'b1, ref_mem[7]});

    // 4: both ports held; DMA only wins once starved (if enabled)
    next_cycle();
    drive_c(1'b1, 10'd20, 32'h20202020, 4'hF);
    drive_d(1'b1, 10'd21, 32'h21212121, 4'hF);
    first_d = -1;
    for (int k = 0; k < 12; k++) begin
      #4;
      if (c_gnt) ref_store(10'd20, 32'h20202020, 4'hF);
      if (d_gnt && first_d < 0) begin
        first_d = k;
        ref_store(10'd21, 32'h21212121, 4'hF);
      end
      next_cycle();
      if (first_d >= 0) d_req = 0;
    end
    c_req = 0;
    d_req = 0;
`ifdef DCCM_ARB_STARVE_EN
    check("t4_starve_cycle", first_d, 4);
`else
    check("t4_starve_cycle", first_d, -1);
`endif

    // 5: reset during the merge cycle drops the write
    drive_c(1'b1, 10'd30, 32'h000000FF, 4'b0001);
    #4;
    check("t5_c_gnt", c_gnt, 1);
    next_cycle();
    c_req = 0;
    rstn = 1'b0;
    #4;
    check("t5_outputs_zero", {c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, m_raddr,
                              m_rvalid_in, m_waddr, m_wen, m_wdata}, '0);
    next_cycle();
    rstn = 1'b1;
    #4;
    check("t5_mem_kept", dmem[30], ref_mem[30]);
    next_cycle();
    drive_c(1'b0, 10'd30, '0, '0);
    #4;
    check("t5_c_gnt_idle", c_gnt, 1);
    next_cycle();
    c_req = 0;
    #4;
    check("t5_readback", {c_rvalid, c_rdata}, {1'b1, ref_mem[30]});

    // Random traffic against the reference model
    next_cycle();
    rmw_busy = 0; cnt = 0; exp_c_rv = 0; exp_d_rv = 0;
    exp_c_data = '0; exp_d_data = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!c_req && $urandom_range(3, 0) != 0)
        drive_c(1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), $urandom, rand_strb());
      if (!d_req && $urandom_range(1, 0) != 0)
        drive_d(1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), $urandom, rand_strb());
      #4;
      check("rnd_c_rvalid", c_rvalid, exp_c_rv);
      if (exp_c_rv) check("rnd_c_rdata", c_rdata, exp_c_data);
      check("rnd_d_rvalid", d_rvalid, exp_d_rv);
      if (exp_d_rv) check("rnd_d_rdata", d_rdata, exp_d_data);
      exp_c_rv = 0;
      exp_d_rv = 0;
      win = 0;
      if (!rmw_busy) begin
        if (d_req && (!c_req || cnt >= StarveMax)) win = 2;
        else if (c_req) win = 1;
        if (d_req && win != 2) cnt++;
        if (win == 2) cnt = 0;
      end
      check("rnd_gnt", {c_gnt, d_gnt}, {win == 1, win == 2});
      busy_next = 0;
      if (win != 0) begin
        t_we   = (win == 1) ? c_we    : d_we;
        t_addr = (win == 1) ? c_addr  : d_addr;
        t_data = (win == 1) ? c_wdata : d_wdata;
        t_strb = (win == 1) ? c_wstrb : d_wstrb;
        if (!t_we) begin
          if (win == 1) begin exp_c_rv = 1; exp_c_data = ref_mem[t_addr]; end
          else begin exp_d_rv = 1; exp_d_data = ref_mem[t_addr]; end
        end else begin
          if (t_strb != 4'h0 && t_strb != 4'hF) busy_next = 1;
          ref_store(t_addr, t_data, t_strb);
        end
      end
      next_cycle();
      rmw_busy = busy_next;
      if (win == 1) c_req = 0;
      if (win == 2) d_req = 0;
    end
    c_req = 0;
    d_req = 0;
    #4;
    check("rnd_tail_rvalid", {c_rvalid, d_rvalid}, {exp_c_rv, exp_d_rv});
    next_cycle();
    next_cycle();
    for (int a = 0; a < 32; a++) check($sformatf("rnd_mem_%0d", a), dmem[a], ref_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
